// File: rtl/simd_alu_array.sv
// Multi-lane SIMD integer ALU with a fixed-depth valid/ready pipeline, per-lane masking and tag passthrough.
// Optional build macro SIMD_ALU_SATURATE_EN: add/sub saturate to signed limits instead of wrapping.
module simd_alu_array #(
  parameter int LANES = 4,
  parameter int W     = 32,
  parameter int PIPE  = 2,
  parameter int TAG_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_op,
  input  logic [LANES-1:0]   in_mask,
  input  logic [LANES*W-1:0] in_a,
  input  logic [LANES*W-1:0] in_b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_data,
  output logic [LANES-1:0]   out_mask,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_MIN = 3'b110;

`ifdef SIMD_ALU_SATURATE_EN
  localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  // Overflow direction follows the sign of the operand that dominated.
  function automatic logic signed [W-1:0] f_sat(input logic neg);
    return neg ? SMIN : SMAX;
  endfunction
`endif

  function automatic logic signed [W-1:0] f_add(input logic signed [W-1:0] a,
                                                input logic signed [W-1:0] b);
    logic signed [W-1:0] s;
    s = a + b;
`ifdef SIMD_ALU_SATURATE_EN
    if ((a[W-1] == b[W-1]) && (s[W-1] != a[W-1])) s = f_sat(a[W-1]);
`endif
    return s;
  endfunction

  function automatic logic signed [W-1:0] f_sub(input logic signed [W-1:0] a,
                                                input logic signed [W-1:0] b);
    logic signed [W-1:0] d;
    d = a - b;
`ifdef SIMD_ALU_SATURATE_EN
    if ((a[W-1] != b[W-1]) && (d[W-1] != a[W-1])) d = f_sat(a[W-1]);
`endif
    return d;
  endfunction

  function automatic logic signed [W-1:0] f_alu(input logic [2:0]          op,
                                                input logic signed [W-1:0] a,
                                                input logic signed [W-1:0] b);
    logic signed [W-1:0] r;
    case (op)
      OP_ADD:  r = f_add(a, b);
      OP_SUB:  r = f_sub(a, b);
      OP_MUL:  r = a * b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_MIN:  r = (a < b) ? a : b;
      default: r = (a < b) ? b : a;
    endcase
    return r;
  endfunction

  logic               w_adv;
  logic               w_accept;
  logic [2:0]         w_op_c;
  logic [LANES*W-1:0] w_a_c;
  logic [LANES*W-1:0] w_b_c;
  logic [LANES*W-1:0] w_res_c;
  logic               w_fin_vld;
  logic [LANES*W-1:0] w_fin_res;
  logic [LANES-1:0]   w_fin_mask;
  logic [TAG_W-1:0]   w_fin_tag;
  logic               w_mid_busy;

  logic               r_vld_pout;
  logic [LANES*W-1:0] r_data_pout;
  logic [LANES-1:0]   r_mask_pout;
  logic [TAG_W-1:0]   r_tag_pout;

  // The whole pipe moves in lockstep; a stalled output freezes every stage.
  assign w_adv    = !r_vld_pout || out_ready;
  assign w_accept = in_valid && w_adv;

  always_comb begin
    w_res_c = '0;
    for (int i = 0; i < LANES; i++)
      w_res_c[i*W +: W] = f_alu(w_op_c, w_a_c[i*W +: W], w_b_c[i*W +: W]);
  end

  if (PIPE == 1) begin : g_single
    assign w_op_c     = in_op;
    assign w_a_c      = in_a;
    assign w_b_c      = in_b;
    assign w_fin_vld  = w_accept;
    assign w_fin_res  = w_res_c;
    assign w_fin_mask = in_mask;
    assign w_fin_tag  = in_tag;
    assign w_mid_busy = 1'b0;
  end else begin : g_multi
    logic               r_vld_p1;
    logic [2:0]         r_op_p1;
    logic [LANES-1:0]   r_mask_p1;
    logic [LANES*W-1:0] r_a_p1;
    logic [LANES*W-1:0] r_b_p1;
    logic [TAG_W-1:0]   r_tag_p1;

    // ---- stage 1: operand capture ----
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_vld_p1 <= 1'b0;
      else if (w_adv) r_vld_p1 <= w_accept;
    end

    always_ff @(posedge clk) begin
      if (w_accept) begin
        r_op_p1   <= in_op;
        r_mask_p1 <= in_mask;
        r_a_p1    <= in_a;
        r_b_p1    <= in_b;
        r_tag_p1  <= in_tag;
      end
    end

    assign w_op_c = r_op_p1;
    assign w_a_c  = r_a_p1;
    assign w_b_c  = r_b_p1;

    if (PIPE == 2) begin : g_direct
      assign w_fin_vld  = r_vld_p1;
      assign w_fin_res  = w_res_c;
      assign w_fin_mask = r_mask_p1;
      assign w_fin_tag  = r_tag_p1;
      assign w_mid_busy = r_vld_p1;
    end else begin : g_delay
      logic               r_vld_pm  [PIPE-2];
      logic [LANES*W-1:0] r_res_pm  [PIPE-2];
      logic [LANES-1:0]   r_mask_pm [PIPE-2];
      logic [TAG_W-1:0]   r_tag_pm  [PIPE-2];

      // ---- stages 2..PIPE-1: result delay line ----
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < PIPE-2; k++) r_vld_pm[k] <= 1'b0;
        end else if (w_adv) begin
          r_vld_pm[0] <= r_vld_p1;
          for (int k = 1; k < PIPE-2; k++) r_vld_pm[k] <= r_vld_pm[k-1];
        end
      end

      always_ff @(posedge clk) begin
        if (w_adv) begin
          r_res_pm[0]  <= w_res_c;
          r_mask_pm[0] <= r_mask_p1;
          r_tag_pm[0]  <= r_tag_p1;
          for (int k = 1; k < PIPE-2; k++) begin
            r_res_pm[k]  <= r_res_pm[k-1];
            r_mask_pm[k] <= r_mask_pm[k-1];
            r_tag_pm[k]  <= r_tag_pm[k-1];
          end
        end
      end

      always_comb begin
        w_mid_busy = r_vld_p1;
        for (int k = 0; k < PIPE-2; k++) w_mid_busy = w_mid_busy | r_vld_pm[k];
      end

      assign w_fin_vld  = r_vld_pm[PIPE-3];
      assign w_fin_res  = r_res_pm[PIPE-3];
      assign w_fin_mask = r_mask_pm[PIPE-3];
      assign w_fin_tag  = r_tag_pm[PIPE-3];
    end
  end

  // ---- output stage: inactive lanes keep their last written value ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pout  <= 1'b0;
      r_data_pout <= '0;
      r_mask_pout <= '0;
      r_tag_pout  <= '0;
    end else if (w_adv) begin
      r_vld_pout <= w_fin_vld;
      if (w_fin_vld) begin
        for (int i = 0; i < LANES; i++)
          if (w_fin_mask[i]) r_data_pout[i*W +: W] <= w_fin_res[i*W +: W];
        r_mask_pout <= w_fin_mask;
        r_tag_pout  <= w_fin_tag;
      end
    end
  end

  assign in_ready  = w_adv;
  assign out_valid = r_vld_pout;
  assign out_data  = r_data_pout;
  assign out_mask  = r_mask_pout;
  assign out_tag   = r_tag_pout;
  assign busy      = w_mid_busy | r_vld_pout;

endmodule

// File: doc/simd_alu_array.md
Name: simd_alu_array

Overview:
- Multi-lane SIMD integer ALU for the shader core execution stage.
- Issues one warp-slice op per cycle across LANES lanes through a fixed-depth pipeline.
- Valid/ready handshake on both sides, per-lane active masking, and a tag carried alongside each op for writeback routing.
- Sits between the operand collector (upstream) and the register-file writeback arbiter (downstream).

Parameters:
- LANES, 4: number of SIMD lanes, >=1.
- W, 32: lane data width in bits, >=8.
- PIPE, 2: pipeline depth in cycles, >=1; equals accept-to-out_valid latency with no stall.
- TAG_W, 6: width of the destination/warp tag carried with each op.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream op valid
- in_ready  out  1  block can accept an op this cycle
- in_op  in  3  000 add, 001 sub (a-b), 010 mul (low W bits), 011 and, 100 or, 101 xor, 110 signed min, 111 signed max
- in_mask  in  LANES  per-lane active mask, bit i = lane i
- in_a  in  LANES*W  operand A, lane i at [i*W +: W]
- in_b  in  LANES*W  operand B, same packing
- in_tag  in  TAG_W  opaque tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  LANES*W  lane results, same packing
- out_mask  out  LANES  mask of the op in out_data
- out_tag  out  TAG_W  tag of the op in out_data
- busy  out  1  any pipeline stage holds a valid op

Behaviour:
- Reset (async, rst_n=0): all stage valid bits 0; out_valid=0; out_data=0; out_mask=0; out_tag=0; busy=0. Reset mid-operation discards every in-flight op, and no partial result appears after release.
- Global advance enable: adv = !out_valid || out_ready. in_ready = adv, which is combinational from out_ready; no in_valid->in_ready path.
- Accept: an op is accepted on a rising clk when in_valid && in_ready. Stage 1 captures op, mask, a, b, tag, valid=1.
- When adv=1: every stage shifts forward one; stage 1 loads the accepted op, or valid=0 if none. When adv=0: all stages hold, including valid bits.
- Bubbles are not collapsed. With PIPE=2 and no stall, an op accepted at cycle t presents out_valid=1 at cycle t+2.
- Compute: lane result is computed combinationally from the registered operands in stage 1. Stages 2..PIPE are delay registers.
  - mul takes the low W bits of the W x W product.
  - add and sub wrap modulo 2^W.
  - min and max compare as two's-complement signed.
- Final stage (out_data) load: on adv with an incoming valid op, lane i loads its result only if mask bit i=1. Lanes with mask=0 retain their previous out_data value, which persists across ops.
- out_mask and out_tag load unconditionally with the op.
- All-zero mask: the op still flows and produces out_valid with out_mask=0, and out_data is unchanged.
- When a bubble enters the final stage on adv: out_valid=0, and out_data/out_mask/out_tag hold.
- Output stability: while out_valid && !out_ready, out_data/out_mask/out_tag are held stable.
- busy = OR of all stage valid bits, including the output stage.
- Throughput: 1 op/cycle when out_ready is held 1.

Optional Feature:
- Macro: SIMD_ALU_SATURATE_EN.
- Defined: add and sub saturate to signed limits, 0x7FFF_FFFF and 0x8000_0000 for W=32, on two's-complement overflow. mul and the other ops are unchanged.
- Undefined: add and sub wrap modulo 2^W. No extra logic.

Test Plan:
- Basic add, PIPE=2, mask=4'b1111, a lanes={1,2,3,0xFFFFFFFF}, b lanes={1,2,3,1}, out_ready=1, accept at t -> out_valid at t+2, out_data lanes={2,4,6,0}, out_tag echoed.
- Masked hold: first op and, mask=1111, a=b=0xA5A5A5A5 -> all lanes 0xA5A5A5A5. Next op add, mask=0101, a=b=1 -> lanes 0 and 2 =2, lanes 1 and 3 stay 0xA5A5A5A5, out_mask=0101.
- Backpressure: stream 4 ops (mul, sub, min, max), out_ready=0 for cycles 3-6.
  - in_ready=0 during the stall; outputs held stable.
  - All 4 results arrive in order, no loss or duplication.
  - Signed min(-5,3)=0xFFFFFFFB; max(-5,3)=3.
- Reset mid-flight: assert rst_n=0 with 2 ops in the pipe -> out_valid=0, busy=0, out_data=0 immediately. No stale output after release.
- Saturation: add 0x7FFFFFFF+1.
  - With SIMD_ALU_SATURATE_EN: 0x7FFFFFFF.
  - Without it: 0x80000000.
  - sub 0x80000000-1 saturates to 0x80000000, or wraps to 0x7FFFFFFF without the macro.
- Zero-mask/bubbles: alternate in_valid 1/0 with one op mask=0000 -> out_valid pattern mirrors the input delayed by PIPE, and the mask=0000 op leaves out_data unchanged.
